// File: rtl/xillybus_lite_pkg.sv
// Shared constants, response codes, read FSM state type and byte-strobe helpers
// for the Xillybus-Lite AXI4-Lite register bank.
package xillybus_lite_pkg;

  localparam logic [3:0] REG_ID         = 4'd0;
  localparam logic [3:0] REG_CTRL       = 4'd1;
  localparam logic [3:0] REG_IRQ_STATUS = 4'd2;
  localparam logic [3:0] REG_IRQ_ENABLE = 4'd3;
  localparam logic [3:0] REG_USER0      = 4'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  // Merge new data into an old word one byte lane at a time.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/xillybus_irq_ctrl.sv
// Interrupt status (W1C, set wins) and enable registers with a registered
// level interrupt output.
module xillybus_irq_ctrl
  import xillybus_lite_pkg::*;
#(
  parameter int C_IRQ_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [C_IRQ_WIDTH-1:0] irq_src,
  input  logic                   status_wr,
  input  logic                   enable_wr,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  output logic [C_IRQ_WIDTH-1:0] status,
  output logic [C_IRQ_WIDTH-1:0] enable,
  output logic                   interrupt
);

  logic [C_IRQ_WIDTH-1:0] status_q, status_d;
  logic [C_IRQ_WIDTH-1:0] enable_q, enable_d;
  logic [C_IRQ_WIDTH-1:0] w1c_mask;
  logic                   irq_q, irq_d;

  // A source sampled high in the same cycle as a clear keeps its bit set.
  always_comb begin
    w1c_mask = '0;
    if (status_wr) begin
      w1c_mask = C_IRQ_WIDTH'(wdata & strb_mask(wstrb));
    end
    status_d = (status_q & ~w1c_mask) | irq_src;

    enable_d = enable_q;
    if (enable_wr) begin
      enable_d = C_IRQ_WIDTH'(apply_wstrb(32'(enable_q), wdata, wstrb));
    end

    irq_d = |(status_q & enable_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= irq_d;
    end
  end

  assign status    = status_q;
  assign enable    = enable_q;
  assign interrupt = irq_q;

endmodule

// File: rtl/xillybus_lite_regs.sv
// AXI4-Lite slave register bank behind the Xillybus-Lite wrapper: ID, CTRL,
// IRQ status/enable and user scratch registers with independent read/write paths.
module xillybus_lite_regs
  import xillybus_lite_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_NUM_REGS         = 16,
  parameter int          C_IRQ_WIDTH        = 8,
  parameter logic [31:0] C_ID               = 32'h58424C01
) (
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  input  logic [C_IRQ_WIDTH-1:0]              irq_src,
  output logic [31:0]                         ctrl,
  output logic [32*(C_NUM_REGS-4)-1:0]        user_regs,
  output logic [C_NUM_REGS-5:0]               user_wr,
  output logic                                Interrupt
);

  localparam int NUM_USER = C_NUM_REGS - 4;
  localparam int WORD_W   = C_S_AXI_ADDR_WIDTH - 2;

  logic                   ready_en_q;

  logic                   aw_held_q, aw_held_d;
  logic [WORD_W-1:0]      awaddr_q, awaddr_d;
  logic                   w_held_q, w_held_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;

  logic [31:0]            ctrl_q, ctrl_d;
  logic [31:0]            user_q [NUM_USER];
  logic [31:0]            user_d [NUM_USER];
  logic [NUM_USER-1:0]    user_wr_q, user_wr_d;

  rd_state_e              rd_state_q;
  logic [31:0]            rdata_q;
  logic [1:0]             rresp_q;

  logic                   aw_hs, w_hs, commit;
  logic [3:0]             wr_idx, rd_idx;
  logic                   wr_oor, rd_oor;
  logic [WORD_W-1:0]      rd_word;
  logic [31:0]            rd_data;
  logic                   status_wr, enable_wr;
  logic [C_IRQ_WIDTH-1:0] irq_status, irq_enable;
  logic [1:0]             unused_addr_bits;

  assign unused_addr_bits = S_AXI_AWADDR[1:0] ^ S_AXI_ARADDR[1:0];

  // Readys stay low until the first edge after reset is released.
  assign S_AXI_AWREADY = ready_en_q & ~aw_held_q;
  assign S_AXI_WREADY  = ready_en_q & ~w_held_q;
  assign S_AXI_ARREADY = ready_en_q & (rd_state_q == R_IDLE);

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  assign wr_idx = awaddr_q[3:0];
  assign wr_oor = (awaddr_q >= WORD_W'(C_NUM_REGS));

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    user_d    = user_q;
    user_wr_d = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Commit waits for the previous response so a stalled BREADY blocks writes.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
      if (!wr_oor) begin
        if (wr_idx == REG_CTRL) begin
          ctrl_d = apply_wstrb(ctrl_q, wdata_q, wstrb_q);
        end
        for (int i = 0; i < NUM_USER; i++) begin
          if (wr_idx == (4'(i) + REG_USER0)) begin
            user_d[i]    = apply_wstrb(user_q[i], wdata_q, wstrb_q);
            user_wr_d[i] = 1'b1;
          end
        end
      end
    end
  end

  assign status_wr = commit & ~wr_oor & (wr_idx == REG_IRQ_STATUS);
  assign enable_wr = commit & ~wr_oor & (wr_idx == REG_IRQ_ENABLE);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ctrl_q     <= '0;
      user_wr_q  <= '0;
      for (int i = 0; i < NUM_USER; i++) begin
        user_q[i] <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ctrl_q     <= ctrl_d;
      user_wr_q  <= user_wr_d;
      for (int i = 0; i < NUM_USER; i++) begin
        user_q[i] <= user_d[i];
      end
    end
  end

  assign rd_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = rd_word[3:0];
  assign rd_oor  = (rd_word >= WORD_W'(C_NUM_REGS));

  // Read mux sees register state before any same-cycle write commit.
  always_comb begin
    rd_data = '0;
    if (!rd_oor) begin
      case (rd_idx)
        REG_ID:         rd_data = C_ID;
        REG_CTRL:       rd_data = ctrl_q;
        REG_IRQ_STATUS: rd_data = 32'(irq_status);
        REG_IRQ_ENABLE: rd_data = 32'(irq_enable);
        default: begin
          for (int i = 0; i < NUM_USER; i++) begin
            if (rd_idx == (4'(i) + REG_USER0)) begin
              rd_data = user_q[i];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (S_AXI_ARVALID && ready_en_q) begin
            rdata_q    <= rd_data;
            rresp_q    <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  xillybus_irq_ctrl #(
    .C_IRQ_WIDTH (C_IRQ_WIDTH)
  ) u_irq_ctrl (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .irq_src   (irq_src),
    .status_wr (status_wr),
    .enable_wr (enable_wr),
    .wdata     (wdata_q),
    .wstrb     (wstrb_q),
    .status    (irq_status),
    .enable    (irq_enable),
    .interrupt (Interrupt)
  );

  for (genvar g = 0; g < NUM_USER; g++) begin : g_user_flat
    assign user_regs[32*g +: 32] = user_q[g];
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (rd_state_q == R_DATA);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign ctrl         = ctrl_q;
  assign user_wr      = user_wr_q;

endmodule

// File: tb/tb_xillybus_lite_regs.sv
// Directed bench for xillybus_lite_regs: a table of single transactions plus
// hand-written sequences for AW/W skew, strobes, IRQ timing, BREADY stall and reset.
module tb_xillybus_lite_regs;

  logic         clk;
  logic         rstN;
  logic [31:0]  awaddr, wdata, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [7:0]   irqSrc;
  logic [31:0]  ctrl;
  logic [383:0] userRegs;
  logic [11:0]  userWr;
  logic         interrupt;

  int checks = 0;
  int errors = 0;
  int pulseCnt = 0;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  expResp;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[14];

  xillybus_lite_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstN),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .irq_src       (irqSrc),
    .ctrl          (ctrl),
    .user_regs     (userRegs),
    .user_wr       (userWr),
    .Interrupt     (interrupt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts user register 0 write pulses so a duplicate commit shows up.
  always @(negedge clk) begin
    if (userWr[0]) pulseCnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timeout actual=no_handshake expected=handshake", name);
  endtask

  // Issues AW then W (W delayed by wDelay cycles); returns at the cycle BVALID is seen.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int wDelay, output logic [1:0] resp);
    bit awDone, wDone, hsA, hsW;
    int cyc;
    awDone = 0; wDone = 0; cyc = 0;
    while (!(awDone && wDone) && cyc < 50) begin
      @(negedge clk);
      awvalid = !awDone;
      awaddr  = addr;
      wvalid  = !wDone && (cyc >= wDelay);
      wdata   = data;
      wstrb   = strb;
      hsA = awvalid && awready;
      hsW = wvalid && wready;
      @(posedge clk);
      if (hsA) awDone = 1;
      if (hsW) wDone = 1;
      cyc++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    resp    = 2'bxx;
    if (!(awDone && wDone)) begin
      timeoutFail("aw_w_handshake");
    end else begin
      checkOutput("bvalid_not_early", 32'(bvalid), 32'd0);
      @(negedge clk);
      checkOutput("bvalid_latency", 32'(bvalid), 32'd1);
      resp = bresp;
    end
  endtask

  task automatic ackB();
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checkOutput("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    hs = 0; cyc = 0;
    data = 'x; resp = 'x;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      arvalid = 1'b1;
      araddr  = addr;
      hs = arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    if (!hs) begin
      timeoutFail("ar_handshake");
    end else begin
      checkOutput("rvalid_latency", 32'(rvalid), 32'd1);
      data = rdata;
      resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checkOutput("rvalid_drop", 32'(rvalid), 32'd0);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0]  resp;
    logic [31:0] data;
    if (v.isWrite) begin
      doWrite(v.addr, v.data, v.strb, 0, resp);
      checkOutput($sformatf("vec%0d_bresp", idx), 32'(resp), 32'(v.expResp));
      ackB();
    end else begin
      doRead(v.addr, data, resp);
      checkOutput($sformatf("vec%0d_rresp", idx), 32'(resp), 32'(v.expResp));
      checkOutput($sformatf("vec%0d_rdata", idx), data, v.expData);
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          base;

    rstN = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    irqSrc = '0;

    vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h58424C01};
    vecs[1]  = '{1'b1, 32'h00, 32'h12345678, 4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h58424C01};
    vecs[3]  = '{1'b1, 32'h3C, 32'h11223344, 4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 32'h3C, 32'h0000AB00, 4'h2, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h3F, 32'h0,        4'h0, 2'b00, 32'h1122AB44};
    vecs[6]  = '{1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h58424C01};
    vecs[9]  = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h000000FF};
    vecs[11] = '{1'b1, 32'h0C, 32'h00000008, 4'hF, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h00000008};
    vecs[13] = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'h00000000};

    // Reset state and ready release timing.
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 32'(awready), 32'd0);
    checkOutput("rst_arready", 32'(arready), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_ctrl", ctrl, 32'd0);
    checkOutput("rst_irq", 32'(interrupt), 32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("release_awready_low", 32'(awready), 32'd0);
    @(negedge clk);
    checkOutput("release_awready", 32'(awready), 32'd1);
    checkOutput("release_wready", 32'(wready), 32'd1);
    checkOutput("release_arready", 32'(arready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], i);
    end

    // AW leads W by three cycles.
    $display("[TB] AW/W skew write to CTRL");
    doWrite(32'h04, 32'hDEADBEEF, 4'hF, 3, resp);
    checkOutput("skew_bresp", 32'(resp), 32'd0);
    checkOutput("skew_ctrl", ctrl, 32'hDEADBEEF);
    ackB();
    doRead(32'h04, data, resp);
    checkOutput("skew_readback", data, 32'hDEADBEEF);

    // Byte strobe on user register 0 with a single write pulse.
    $display("[TB] strobed write to user register 0");
    doWrite(32'h10, 32'h11223344, 4'hF, 0, resp);
    ackB();
    base = pulseCnt;
    doWrite(32'h10, 32'h0000AB00, 4'b0010, 0, resp);
    checkOutput("strb_user_wr", 32'(userWr[0]), 32'd1);
    checkOutput("strb_value", userRegs[31:0], 32'h1122AB44);
    ackB();
    repeat (3) @(negedge clk);
    checkOutput("strb_pulse_count", 32'(pulseCnt - base), 32'd1);

    // IRQ source pulse with enable bit 3 already set.
    $display("[TB] interrupt set and clear timing");
    irqSrc = 8'h08;
    @(negedge clk);
    irqSrc = 8'h00;
    checkOutput("irq_not_early", 32'(interrupt), 32'd0);
    @(negedge clk);
    checkOutput("irq_rise", 32'(interrupt), 32'd1);
    irqSrc = 8'h08;
    doWrite(32'h08, 32'h08, 4'hF, 0, resp);
    irqSrc = 8'h00;
    ackB();
    doRead(32'h08, data, resp);
    checkOutput("irq_set_wins", data, 32'h08);
    checkOutput("irq_still_high", 32'(interrupt), 32'd1);
    doWrite(32'h08, 32'h08, 4'hF, 0, resp);
    checkOutput("irq_fall_not_early", 32'(interrupt), 32'd1);
    ackB();
    checkOutput("irq_fall", 32'(interrupt), 32'd0);
    doRead(32'h08, data, resp);
    checkOutput("irq_status_cleared", data, 32'h0);

    // BREADY stalled while a second write is queued.
    $display("[TB] BREADY stall");
    doWrite(32'h14, 32'h1, 4'hF, 0, resp);
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h14;
    wvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall_bvalid_%0d", i), 32'(bvalid), 32'd1);
      checkOutput($sformatf("stall_awready_%0d", i), 32'(awready), 32'd0);
      checkOutput($sformatf("stall_wready_%0d", i), 32'(wready), 32'd0);
      checkOutput($sformatf("stall_value_%0d", i), userRegs[63:32], 32'h1);
      @(negedge clk);
    end
    ackB();
    checkOutput("stall_value_before_commit", userRegs[63:32], 32'h1);
    @(negedge clk);
    checkOutput("stall_second_bvalid", 32'(bvalid), 32'd1);
    checkOutput("stall_second_value", userRegs[63:32], 32'h2);
    ackB();

    // Reset in the middle of a pending read response and a held AW.
    $display("[TB] reset mid-transaction");
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h04;
    awvalid = 1'b1; awaddr = 32'h18;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    checkOutput("pre_reset_rvalid", 32'(rvalid), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("mid_rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("mid_rst_awready", 32'(awready), 32'd0);
    checkOutput("mid_rst_ctrl", ctrl, 32'd0);
    checkOutput("mid_rst_user", userRegs[31:0], 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rerelease_arready_low", 32'(arready), 32'd0);
    @(negedge clk);
    checkOutput("rerelease_awready", 32'(awready), 32'd1);
    checkOutput("rerelease_arready", 32'(arready), 32'd1);
    checkOutput("rerelease_bvalid", 32'(bvalid), 32'd0);
    doRead(32'h04, data, resp);
    checkOutput("post_rst_ctrl_read", data, 32'd0);
    doRead(32'h0C, data, resp);
    checkOutput("post_rst_enable_read", data, 32'd0);
    doRead(32'h14, data, resp);
    checkOutput("post_rst_user1_read", data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
